load_store_unit: RTL and testbench
==================================

# load_store_unit

Execute-to-memory stage of the monocycle core: consumes the ALU result as an effective address together with the rs2 store value. It performs byte, halfword and word loads and stores over a request/acknowledge data-memory port, and returns sign- or zero-extended load data to writeback. While a transaction is in flight it stalls the core through `Busy`. It also reports misaligned, illegal or timed-out accesses through `Fault`.

## Interface
- `TIMEOUT`, default 16: maximum cycles in REQ waiting for `MemAck` before abort; range 1..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `AluRes`  in  32  effective address from the ALU.
- `StoreData`  in  32  rs2 value for stores.
- `MemRead`  in  1  load request for the current instruction.
- `MemWrite`  in  1  store request for the current instruction.
- `Funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `Busy`  out  1  combinational stall to the PC/register-file enables.
- `Done`  out  1  one-cycle pulse; access complete, `LoadData`/`Fault` valid.
- `Fault`  out  1  valid with `Done`; access aborted or illegal.
- `LoadData`  out  32  extended load result; holds until the next `Done`.
- `MemReq`  out  1  memory request, held until acknowledged.
- `MemWe`  out  1  1 = write.
- `MemAddr`  out  32  word-aligned address, `{AluRes[31:2],2'b00}`.
- `MemBe`  out  4  byte-lane enables.
- `MemWData`  out  32  lane-replicated store data.
- `MemAck`  in  1  memory completion; `MemRData` valid in the same cycle.
- `MemRData`  in  32  read word.

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- IDLE behaviour:
  - `Start` = `MemRead | MemWrite`.
  - If both are set, the store wins and the read is ignored.
- On `Start` in IDLE, the unit checks legality:
  - Illegal `Funct3`: a load with 011/110/111, or a store with anything other than 000/001/010.
  - Misaligned address: H/HU/SH with `AluRes[0]`=1, or W/SW with `AluRes[1:0]`≠00.
- If the access is illegal or misaligned: no memory access occurs; go to DONE with `Fault`=1 and `LoadData`=0.
- If the access is legal: register `MemAddr`, `MemBe`, `MemWData` and `MemWe`, set `MemReq`=1, clear the timeout counter, and go to REQ.
- Byte-lane rules (`a` = `AluRes[1:0]`):
  - Byte: `MemBe` = 0001<<a; `MemWData` = {4{StoreData[7:0]}}.
  - Half: `MemBe` = a[1] ? 1100 : 0011; `MemWData` = {2{StoreData[15:0]}}.
  - Word: `MemBe` = 1111; `MemWData` = `StoreData`.
  - Loads drive the same `MemBe` as stores of the same size.
- REQ behaviour:
  - `MemReq` and all `Mem*` outputs stay stable.
  - On `MemAck`=1: drop `MemReq` and go to DONE. For loads, register `LoadData`, where the lane is selected by the latched `a` and extended by `Funct3`:
    - B/H: sign-extended.
    - BU/HU: zero-extended.
  - If `MemAck` has not arrived after `TIMEOUT` cycles in REQ: drop `MemReq`, go to DONE, set `Fault`=1 and `LoadData`=0.
- DONE behaviour:
  - `Done`=1 and `Busy`=0 for exactly one cycle, so the core retires the instruction on this edge.
  - The still-asserted `MemRead`/`MemWrite` inputs are ignored.
  - Always returns to IDLE.
- `Busy` = (IDLE & `Start`) | REQ. It is 0 while `rst_n`=0.
- `MemAck` outside REQ is ignored.
- Stores leave `LoadData` unchanged.

## Timing
- Reset (`rst_n`=0 at an edge), from any state including mid-REQ: go to IDLE.
- Output values after reset:
  - `MemReq`, `MemWe`, `Done` and `Fault` = 0.
  - `MemBe` = 0000.
  - `MemAddr`, `MemWData` and `LoadData` = 0.
  - An acknowledge arriving later is ignored.
- Legal access with `MemAck` arriving k cycles after `MemReq` rises (k≥0 means ack in the first REQ cycle):
  - Cycle 0: IDLE accept, `Busy`=1.
  - Cycles 1..1+k: REQ.
  - Cycle 2+k: DONE with `Done`=1.
  - Total instruction occupancy is 3+k cycles.
- Illegal or misaligned access:
  - Cycle 0: accept with `Busy`=1.
  - Cycle 1: DONE with `Done`=1 and `Fault`=1.
- Timeout:
  - `MemReq` is high for exactly `TIMEOUT` cycles.
  - DONE follows on the next cycle.
  - An ack in the same cycle as the timeout expiry counts as success.
- Back-to-back accesses: the earliest next accept is the cycle after DONE.
- `Fault` and `Done` are registered pulses; each is high for exactly one cycle.

## Test plan
- Load byte with sign extension:
  - Stimulus: LB with `AluRes`=0x1003, `MemRData`=0x80FF1234, ack at k=0.
  - Required: `MemAddr`=0x1000, `MemBe`=1000, `Done` in cycle 2, `LoadData`=0xFFFFFF80.
  - Repeat as LBU; required `LoadData`=0x00000080.
- Store halfword to the upper half:
  - Stimulus: SH with `AluRes`=0x2002, `StoreData`=0xDEADBEEF, ack at k=3.
  - Required: `MemWe`=1, `MemBe`=1100, `MemWData`=0xBEEFBEEF, `MemReq` high 4 cycles, `Done` in cycle 5, `LoadData` unchanged.
- Misaligned word load:
  - Stimulus: LW with `AluRes`=0x3001.
  - Required: `MemReq` never rises; `Done`=`Fault`=1 in cycle 1; `LoadData`=0.
  - Repeat with `Funct3`=110; required response is identical.
- Timeout:
  - Stimulus: `TIMEOUT`=4, SW with no ack.
  - Required: `MemReq` high cycles 1-4, `Done`+`Fault` in cycle 5.
  - Repeat with ack in cycle 4; required: no `Fault`.
- Reset mid-transaction:
  - Stimulus: LW in REQ, `rst_n`=0 for one edge, ack presented one cycle later.
  - Required: all outputs at reset values, `Done` never asserted, next LW completes normally.
- Simultaneous requests and DONE hold-over:
  - Stimulus: `MemRead`=`MemWrite`=1, SW to 0x4000.
  - Required: a write is performed.
  - Then hold the inputs through DONE; required: no second request is issued.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge bus between the load/store unit and memory.
// The LSU drives the request side; memory returns the acknowledge and read word.
interface load_store_unit_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBe;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq,
        output MemWe,
        output MemAddr,
        output MemBe,
        output MemWData,
        input  MemAck,
        input  MemRData
    );

    modport slave (
        input  MemReq,
        input  MemWe,
        input  MemAddr,
        input  MemBe,
        input  MemWData,
        output MemAck,
        output MemRData
    );
endinterface

// File: rtl/load_store_unit.sv
// Execute-to-memory load/store unit: byte/half/word accesses over a req/ack
// memory port, with sign/zero extension, core stall and fault reporting.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] AluRes,
    input  logic [31:0] StoreData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    output logic        Busy,
    output logic        Done,
    output logic        Fault,
    output logic [31:0] LoadData,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    // Byte-lane enables for a given size (Funct3[1:0]) and byte offset.
    function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] offs);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << offs;
            2'b01:   be = offs[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the access could touch.
    function automatic logic [31:0] laneData(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        case (size)
            2'b00:   wd = {4{sd[7:0]}};
            2'b01:   wd = {2{sd[15:0]}};
            2'b10:   wd = sd;
            default: wd = 32'h0000_0000;
        endcase
        return wd;
    endfunction

    // Selects the addressed lane from the read word and extends it.
    function automatic logic [31:0] extractLoad(input logic [2:0] f3, input logic [1:0] offs,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (offs)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = offs[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b010:  res = rd;
            3'b100:  res = {24'h000000, b};
            3'b101:  res = {16'h0000, h};
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Stores only allow signed-size encodings; loads also allow BU/HU.
    function automatic logic funct3Legal(input logic isStore, input logic [2:0] f3);
        logic ok;
        if (isStore) begin
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end else begin
            ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        end
        return ok;
    endfunction

    // Half accesses need an even address, word accesses a word-aligned one.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] offs);
        return ((f3[1:0] == 2'b01) && offs[0]) || ((f3[1:0] == 2'b10) && (offs != 2'b00));
    endfunction

    state_t      state_r;
    logic [7:0]  timeoutCnt_r;
    logic        isStore_r;
    logic [2:0]  funct3_r;
    logic [1:0]  byteOff_r;
    logic        memReq_r;
    logic        memWe_r;
    logic [31:0] memAddr_r;
    logic [3:0]  memBe_r;
    logic [31:0] memWData_r;
    logic        done_r;
    logic        fault_r;
    logic [31:0] loadData_r;

    logic        start_s;
    logic        isStore_s;
    logic        accessOk_s;
    logic [3:0]  beNext_s;
    logic [31:0] wdNext_s;
    logic        busy_s;

    // Decode of the incoming instruction and the combinational stall.
    always_comb begin
        start_s    = MemRead | MemWrite;
        isStore_s  = MemWrite;
        accessOk_s = funct3Legal(isStore_s, Funct3) && !misaligned(Funct3, AluRes[1:0]);
        beNext_s   = laneEnable(Funct3[1:0], AluRes[1:0]);
        wdNext_s   = laneData(Funct3[1:0], StoreData);
        busy_s     = rst_n && (((state_r == ST_IDLE) && start_s) || (state_r == ST_REQ));
    end

    // Transaction FSM with all outputs except Busy registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            timeoutCnt_r <= 8'h00;
            isStore_r    <= 1'b0;
            funct3_r     <= 3'b000;
            byteOff_r    <= 2'b00;
            memReq_r     <= 1'b0;
            memWe_r      <= 1'b0;
            memAddr_r    <= 32'h0000_0000;
            memBe_r      <= 4'b0000;
            memWData_r   <= 32'h0000_0000;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
            loadData_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                    if (start_s) begin
                        if (!accessOk_s) begin
                            // Rejected before the bus is touched.
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            fault_r    <= 1'b1;
                            loadData_r <= 32'h0000_0000;
                        end else begin
                            state_r      <= ST_REQ;
                            timeoutCnt_r <= 8'h00;
                            isStore_r    <= isStore_s;
                            funct3_r     <= Funct3;
                            byteOff_r    <= AluRes[1:0];
                            memReq_r     <= 1'b1;
                            memWe_r      <= isStore_s;
                            memAddr_r    <= {AluRes[31:2], 2'b00};
                            memBe_r      <= beNext_s;
                            memWData_r   <= wdNext_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // An ack on the expiry cycle still completes the access.
                    if (mem.MemAck) begin
                        state_r  <= ST_DONE;
                        memReq_r <= 1'b0;
                        done_r   <= 1'b1;
                        fault_r  <= 1'b0;
                        if (!isStore_r) begin
                            loadData_r <= extractLoad(funct3_r, byteOff_r, mem.MemRData);
                        end else begin
                            loadData_r <= loadData_r;
                        end
                    end else if (timeoutCnt_r == TO_LAST) begin
                        state_r    <= ST_DONE;
                        memReq_r   <= 1'b0;
                        done_r     <= 1'b1;
                        fault_r    <= 1'b1;
                        loadData_r <= 32'h0000_0000;
                    end else begin
                        timeoutCnt_r <= timeoutCnt_r + 8'h01;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    memReq_r <= 1'b0;
                    done_r   <= 1'b0;
                    fault_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy         = busy_s;
    assign Done         = done_r;
    assign Fault        = fault_r;
    assign LoadData     = loadData_r;
    assign mem.MemReq   = memReq_r;
    assign mem.MemWe    = memWe_r;
    assign mem.MemAddr  = memAddr_r;
    assign mem.MemBe    = memBe_r;
    assign mem.MemWData = memWData_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// requests and completions; independent monitors pop and compare them.
module tb_load_store_unit;

    localparam int TO = 4;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          cyc;
    } doneExp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          len;
    } reqExp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] AluRes;
    logic [31:0] StoreData;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic        Busy;
    logic        Done;
    logic        Fault;
    logic [31:0] LoadData;

    load_store_unit_if memBus();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .AluRes    (AluRes),
        .StoreData (StoreData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .Busy      (Busy),
        .Done      (Done),
        .Fault     (Fault),
        .LoadData  (LoadData),
        .mem       (memBus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    doneExp_t doneQ[$];
    reqExp_t  reqQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor.
    initial forever begin
        @(negedge clk);
        if (Done || Fault) begin
            chk("fault_only_with_done", {31'b0, Fault & ~Done}, 32'h0);
        end
        if (Done) begin
            if (doneQ.size() == 0) begin
                chk("unexpected_done", 32'h1, 32'h0);
            end else begin
                doneExp_t e;
                e = doneQ.pop_front();
                chk("done_fault", {31'b0, Fault}, {31'b0, e.fault});
                chk("done_loaddata", LoadData, e.data);
                chk("done_cycle", cyc, e.cyc);
                chk("done_busy_low", {31'b0, Busy}, 32'h0);
            end
        end
    end

    // Memory-side request monitor.
    initial begin
        logic    prevReq;
        int      reqLen;
        reqExp_t cur;
        prevReq = 1'b0;
        reqLen  = 0;
        cur     = '{we: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, len: 0};
        forever begin
            @(negedge clk);
            if (memBus.MemReq && !prevReq) begin
                reqLen = 1;
                if (reqQ.size() == 0) begin
                    chk("unexpected_request", 32'h1, 32'h0);
                end else begin
                    cur = reqQ.pop_front();
                    chk("req_we", {31'b0, memBus.MemWe}, {31'b0, cur.we});
                    chk("req_addr", memBus.MemAddr, cur.addr);
                    chk("req_be", {28'b0, memBus.MemBe}, {28'b0, cur.be});
                    if (cur.we) chk("req_wdata", memBus.MemWData, cur.wdata);
                end
            end else if (memBus.MemReq) begin
                reqLen++;
            end else if (prevReq) begin
                chk("req_length", reqLen, cur.len);
            end
            prevReq = memBus.MemReq;
        end
    end

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_busy"},   {31'b0, Busy}, 32'h0);
        chk({tag, "_done"},   {31'b0, Done}, 32'h0);
        chk({tag, "_fault"},  {31'b0, Fault}, 32'h0);
        chk({tag, "_ldata"},  LoadData, 32'h0);
        chk({tag, "_memreq"}, {31'b0, memBus.MemReq}, 32'h0);
        chk({tag, "_memwe"},  {31'b0, memBus.MemWe}, 32'h0);
        chk({tag, "_membe"},  {28'b0, memBus.MemBe}, 32'h0);
        chk({tag, "_addr"},   memBus.MemAddr, 32'h0);
        chk({tag, "_wdata"},  memBus.MemWData, 32'h0);
    endtask

    // One instruction; entered and left at #1 after a rising edge in IDLE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdat,
                          input int k, input logic reqExpected, input logic [3:0] be,
                          input logic [31:0] wdata, input int len, input logic fault,
                          input logic [31:0] data, input int lat, input logic hold);
        int n;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        AluRes    = addr;
        StoreData = sd;
        doneQ.push_back('{fault: fault, data: data, cyc: cyc + lat});
        if (reqExpected)
            reqQ.push_back('{we: wr, addr: addr & 32'hFFFF_FFFC, be: be, wdata: wdata, len: len});
        #1;
        chk("busy_at_accept", {31'b0, Busy}, 32'h1);
        if (k >= 0) begin
            repeat (1 + k) @(posedge clk);
            #1;
            memBus.MemAck   = 1'b1;
            memBus.MemRData = rdat;
            @(posedge clk);
            #1;
            memBus.MemAck   = 1'b0;
            memBus.MemRData = 32'h0;
        end
        n = 0;
        while (!Done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!Done) chk("done_wait_expired", 32'h0, 32'h1);
        if (hold) begin
            @(posedge clk);
            #1;
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n           = 1'b0;
        MemRead         = 1'b1;
        MemWrite        = 1'b0;
        Funct3          = 3'b010;
        AluRes          = 32'h0;
        StoreData       = 32'h0;
        memBus.MemAck   = 1'b0;
        memBus.MemRData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        MemRead = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;

        // LB / LBU from the top byte lane.
        access(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
               1'b1, 4'b1000, 32'h0, 1, 1'b0, 32'hFFFF_FF80, 2, 1'b0);
        access(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0,
               1'b1, 4'b1000, 32'h0, 1, 1'b0, 32'h0000_0080, 2, 1'b0);
        // SH to the upper half, ack after 3 wait cycles; LoadData unchanged.
        access(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0, 3,
               1'b1, 4'b1100, 32'hBEEF_BEEF, 4, 1'b0, 32'h0000_0080, 5, 1'b0);
        // Misaligned LW: no bus request, immediate fault.
        access(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, -1,
               1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h0, 1, 1'b0);
        // LH upper half, sign-extended.
        access(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1,
               1'b1, 4'b1100, 32'h0, 2, 1'b0, 32'hFFFF_80FF, 3, 1'b0);
        // Illegal load encoding 110.
        access(1'b1, 1'b0, 3'b110, 32'h0000_3001, 32'h0, 32'h0, -1,
               1'b0, 4'b0000, 32'h0, 0, 1'b1, 32'h0, 1, 1'b0);
        // LHU lower half, zero-extended.
        access(1'b1, 1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h1234_ABCD, 0,
               1'b1, 4'b0011, 32'h0, 1, 1'b0, 32'h0000_ABCD, 2, 1'b0);
        // SW with no ack: timeout after TO cycles of MemReq.
        access(1'b0, 1'b1, 3'b010, 32'h0000_5000, 32'h0F0F_1234, 32'h0, -1,
               1'b1, 4'b1111, 32'h0F0F_1234, 4, 1'b1, 32'h0, 5, 1'b0);
        // SW with ack on the expiry cycle: success.
        access(1'b0, 1'b1, 3'b010, 32'h0000_5004, 32'h55AA_55AA, 32'h0, 3,
               1'b1, 4'b1111, 32'h55AA_55AA, 4, 1'b0, 32'h0, 5, 1'b0);
        // SB to lane 1.
        access(1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h0, 1,
               1'b1, 4'b0010, 32'hA5A5_A5A5, 2, 1'b0, 32'h0, 3, 1'b0);
        access(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h1122_3344, 0,
               1'b1, 4'b1111, 32'h0, 1, 1'b0, 32'h1122_3344, 2, 1'b0);

        // Reset while in REQ; a late ack must be ignored.
        MemRead = 1'b1;
        Funct3  = 3'b010;
        AluRes  = 32'h0000_6000;
        reqQ.push_back('{we: 1'b0, addr: 32'h0000_6000, be: 4'b1111, wdata: 32'h0, len: 2});
        #1;
        chk("busy_at_accept", {31'b0, Busy}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b0;
        MemRead = 1'b0;
        @(posedge clk);
        #1;
        rst_n           = 1'b1;
        memBus.MemAck   = 1'b1;
        memBus.MemRData = 32'hBAD0_BAD0;
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        memBus.MemAck   = 1'b0;
        memBus.MemRData = 32'h0;
        chk("late_ack_no_req", {31'b0, memBus.MemReq}, 32'h0);
        chk("late_ack_no_done", {31'b0, Done}, 32'h0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'hCAFE_F00D, 2,
               1'b1, 4'b1111, 32'h0, 3, 1'b0, 32'hCAFE_F00D, 4, 1'b0);

        // Read and write together: store wins; inputs held through DONE.
        access(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0BAD_CAFE, 32'hFFFF_FFFF, 0,
               1'b1, 4'b1111, 32'h0BAD_CAFE, 1, 1'b0, 32'hCAFE_F00D, 2, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        chk("no_second_request", {31'b0, memBus.MemReq}, 32'h0);
        chk("pending_done_expectations", doneQ.size(), 32'h0);
        chk("pending_req_expectations", reqQ.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
